// File: rtl/supersample_sched.sv
// Block sequencer in front of supersample_top: MCU channel ordering, drain gap, frame counting.
// Optional channel-order checking is enabled with `define SUPERSAMPLE_SCHED_CHK_EN.
module supersample_sched #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MCU_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_420,
    input  logic [MCU_W-1:0]   frame_mcus,
    input  logic               in_valid,
    input  logic [1:0]         in_ch,
    input  logic [575:0]       in_block,
    output logic               in_ready,
    output logic               ss_valid,
    output logic [1:0]         ss_ch,
    output logic [575:0]       ss_block,
    output logic               busy,
    output logic               frame_done,
    output logic               seq_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_Y     = 3'd1,
        S_CB    = 3'd2,
        S_CR    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state_r;
    logic               mode_420_r;
    logic [MCU_W-1:0]   frame_mcus_r;
    logic [MCU_W-1:0]   mcu_cnt_r;
    logic [2:0]         y_cnt_r;
    logic [3:0]         drain_cnt_r;
    logic               frame_done_r;
    logic               ss_valid_r;
    logic [1:0]         ss_ch_r;
    logic [575:0]       ss_block_r;

    logic               accept_s;
    logic               start_acc_s;
    logic               y_last_s;
    logic [1:0]         exp_ch_s;
    logic               ready_s;
    logic [MCU_W-1:0]   mcu_next_s;

    // State decode: handshake ready and the channel the current state expects
    always_comb begin
        ready_s  = 1'b0;
        exp_ch_s = 2'd0;
        case (state_r)
            S_Y: begin
                ready_s  = 1'b1;
                exp_ch_s = 2'd0;
            end
            S_CB: begin
                ready_s  = 1'b1;
                exp_ch_s = 2'd1;
            end
            S_CR: begin
                ready_s  = 1'b1;
                exp_ch_s = 2'd2;
            end
            default: begin
                ready_s  = 1'b0;
                exp_ch_s = 2'd0;
            end
        endcase
    end

    assign accept_s    = in_valid && ready_s;
    assign start_acc_s = start && (state_r == S_IDLE);
    assign y_last_s    = mode_420_r ? (y_cnt_r == 3'd3) : 1'b1;
    assign mcu_next_s  = mcu_cnt_r + MCU_W'(1);

    // Sequencing FSM with frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            mode_420_r   <= 1'b0;
            frame_mcus_r <= '0;
            mcu_cnt_r    <= '0;
            y_cnt_r      <= 3'd0;
            drain_cnt_r  <= 4'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_420_r   <= mode_420;
                        frame_mcus_r <= frame_mcus;
                        mcu_cnt_r    <= '0;
                        y_cnt_r      <= 3'd0;
                        if (frame_mcus == '0) begin
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r <= S_Y;
                        end
                    end
                end
                S_Y: begin
                    if (accept_s) begin
                        y_cnt_r <= y_cnt_r + 3'd1;
                        if (y_last_s) begin
                            state_r <= S_CB;
                        end
                    end
                end
                S_CB: begin
                    if (accept_s) begin
                        state_r <= S_CR;
                    end
                end
                S_CR: begin
                    if (accept_s) begin
                        mcu_cnt_r <= mcu_next_s;
                        if (DRAIN_CYCLES > 0) begin
                            state_r     <= S_DRAIN;
                            drain_cnt_r <= 4'(DRAIN_CYCLES - 1);
                        end else if (mcu_next_s == frame_mcus_r) begin
                            state_r      <= S_IDLE;
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r <= S_Y;
                            y_cnt_r <= 3'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == 4'd0) begin
                        if (mcu_cnt_r == frame_mcus_r) begin
                            state_r      <= S_IDLE;
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r <= S_Y;
                            y_cnt_r <= 3'd0;
                        end
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage: one-cycle registered forward, tagged by state rather than in_ch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_valid_r <= 1'b0;
            ss_ch_r    <= 2'd0;
            ss_block_r <= '0;
        end else begin
            ss_valid_r <= accept_s;
            if (accept_s) begin
                ss_ch_r    <= exp_ch_s;
                ss_block_r <= in_block;
            end
        end
    end

`ifdef SUPERSAMPLE_SCHED_CHK_EN
    logic seq_err_r;

    // Sticky channel-order error, cleared by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_r <= 1'b0;
        end else if (start_acc_s) begin
            seq_err_r <= 1'b0;
        end else if (accept_s && (in_ch != exp_ch_s)) begin
            seq_err_r <= 1'b1;
        end
    end

    assign seq_err = seq_err_r;
`else
    logic unused_chk_s;
    assign unused_chk_s = ^{in_ch, start_acc_s};
    assign seq_err      = 1'b0;
`endif

    assign in_ready   = ready_s;
    assign busy       = (state_r != S_IDLE);
    assign frame_done = frame_done_r;
    assign ss_valid   = ss_valid_r;
    assign ss_ch      = ss_ch_r;
    assign ss_block   = ss_block_r;

endmodule

// File: tb/tb_supersample_sched.sv
// Directed bench for supersample_sched with default parameters (DRAIN_CYCLES = 2, MCU_W = 16).
module tb_supersample_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode_420;
    logic [15:0]   frame_mcus;
    logic          in_valid;
    logic [1:0]    in_ch;
    logic [575:0]  in_block;
    logic          in_ready;
    logic          ss_valid;
    logic [1:0]    ss_ch;
    logic [575:0]  ss_block;
    logic          busy;
    logic          frame_done;
    logic          seq_err;

    int            n_chk  = 0;
    int            n_pass = 0;

    logic [11:0]   valid_tr, ready_tr, busy_tr, done_tr;
    int            n_valid, n_done;
    logic          seqerr_c0, seqerr_end;
    logic          exp_seqerr;

    supersample_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_420   (mode_420),
        .frame_mcus (frame_mcus),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_block   (in_block),
        .in_ready   (in_ready),
        .ss_valid   (ss_valid),
        .ss_ch      (ss_ch),
        .ss_block   (ss_block),
        .busy       (busy),
        .frame_done (frame_done),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [575:0] mk_blk(input int k);
        logic [575:0] b;
        for (int p = 0; p < 64; p++) begin
            b[p*9 +: 9] = 9'((k * 37 + p * 5 + 1) & 511);
        end
        return b;
    endfunction

    function automatic logic [1:0] exp_chan(input logic m, input int k);
        int p;
        if (m) begin
            p = k % 6;
            return (p < 4) ? 2'd0 : 2'(p - 3);
        end
        return 2'(k % 3);
    endfunction

    // One frame: start at edge 0, trace samples c = 0..11 taken 1 time unit after edge c.
    task automatic run_frame(input logic m420, input logic [15:0] mcus, input logic [31:0] vmask,
                             input int restart_c, input logic bad_ch, input int base);
        int   acc, outn, c, total;
        logic will, done_seen;
        total = int'(mcus) * (m420 ? 6 : 3);
        valid_tr = '0; ready_tr = '0; busy_tr = '0; done_tr = '0;
        n_done = 0; acc = 0; outn = 0; c = 0; done_seen = 1'b0;
        start = 1'b1; mode_420 = m420; frame_mcus = mcus; in_valid = 1'b0;
        in_block = mk_blk(base); in_ch = 2'd0;
        will = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (c < 300) begin
            if (will) acc++;
            if (c < 12) begin
                valid_tr[c] = ss_valid; ready_tr[c] = in_ready;
                busy_tr[c]  = busy;     done_tr[c]  = frame_done;
            end
            if (c == 0) seqerr_c0 = seq_err;
            if (ss_valid) begin
                check($sformatf("ss_ch[%0d]", outn), ss_ch, exp_chan(m420, outn));
                check($sformatf("ss_block[%0d]", outn), ss_block, mk_blk(base + outn));
                outn++;
            end
            if (frame_done) begin
                n_done++;
                done_seen = 1'b1;
                check("busy_at_done", busy, 1'b0);
            end
            if (done_seen && c >= 11) break;
            if (c == restart_c) begin
                start = 1'b1; frame_mcus = mcus + 16'd4; mode_420 = ~m420;
            end else begin
                start = 1'b0;
            end
            in_valid = (acc < total) && vmask[c % 32];
            in_block = mk_blk(base + acc);
            in_ch    = (bad_ch && acc == 0) ? 2'd2 : exp_chan(m420, acc);
            will     = in_valid && in_ready;
            @(posedge clk); #1;
            c++;
        end
        if (!done_seen) check("frame_timeout", 1'b0, 1'b1);
        n_valid    = outn;
        seqerr_end = seq_err;
        in_valid   = 1'b0;
        start      = 1'b0;
        mode_420   = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_in_ready"},   in_ready,   1'b0);
        check({pfx, "_ss_valid"},   ss_valid,   1'b0);
        check({pfx, "_ss_ch"},      ss_ch,      2'd0);
        check({pfx, "_ss_block"},   ss_block,   576'd0);
        check({pfx, "_busy"},       busy,       1'b0);
        check({pfx, "_frame_done"}, frame_done, 1'b0);
        check({pfx, "_seq_err"},    seq_err,    1'b0);
    endtask

    initial begin
`ifdef SUPERSAMPLE_SCHED_CHK_EN
        exp_seqerr = 1'b1;
`else
        exp_seqerr = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; mode_420 = 1'b0; frame_mcus = 16'd0;
        in_valid = 1'b0; in_ch = 2'd0; in_block = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 4:2:0, one MCU, valid held high
        run_frame(1'b1, 16'd1, 32'hFFFF_FFFF, -1, 1'b0, 0);
        check("t1_valid_trace", valid_tr, 12'h07E);
        check("t1_ready_trace", ready_tr, 12'h03F);
        check("t1_busy_trace",  busy_tr,  12'h0FF);
        check("t1_done_trace",  done_tr,  12'h100);
        check("t1_n_valid", n_valid, 6);
        check("t1_n_done",  n_done,  1);

        // 4:4:4, two MCUs: 0,1,2, gap of 2, 0,1,2
        run_frame(1'b0, 16'd2, 32'hFFFF_FFFF, -1, 1'b0, 100);
        check("t2_valid_trace", valid_tr, 12'h1CE);
        check("t2_busy_trace",  busy_tr,  12'h3FF);
        check("t2_done_trace",  done_tr,  12'h400);
        check("t2_n_valid", n_valid, 6);
        check("t2_n_done",  n_done,  1);

        // 4:2:0, three MCUs with upstream bubbles
        run_frame(1'b1, 16'd3, 32'hB5D3_6E9B, -1, 1'b0, 200);
        check("t3_n_valid", n_valid, 18);
        check("t3_n_done",  n_done,  1);

        // empty frame
        run_frame(1'b1, 16'd0, 32'hFFFF_FFFF, -1, 1'b0, 300);
        check("t4_done_trace",  done_tr,  12'h001);
        check("t4_busy_trace",  busy_tr,  12'h000);
        check("t4_valid_trace", valid_tr, 12'h000);
        check("t4_n_done", n_done, 1);

        // start while busy is ignored (would change mode and MCU count if taken)
        run_frame(1'b1, 16'd1, 32'hFFFF_FFFF, 3, 1'b0, 400);
        check("t5_valid_trace", valid_tr, 12'h07E);
        check("t5_done_trace",  done_tr,  12'h100);
        check("t5_n_valid", n_valid, 6);

        // reset after the 2nd Y accept
        start = 1'b1; mode_420 = 1'b1; frame_mcus = 16'd1;
        in_valid = 1'b1; in_ch = 2'd0; in_block = mk_blk(500);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_block = mk_blk(501);
        @(posedge clk); #1;
        check("t6_pre_rst_valid", ss_valid, 1'b1);
        check("t6_pre_rst_block", ss_block, mk_blk(501));
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b1, 16'd1, 32'hFFFF_FFFF, -1, 1'b0, 600);
        check("t6_valid_trace", valid_tr, 12'h07E);
        check("t6_done_trace",  done_tr,  12'h100);
        check("t6_n_valid", n_valid, 6);

        // wrong channel on the first Y accept
        run_frame(1'b1, 16'd1, 32'hFFFF_FFFF, -1, 1'b1, 700);
        check("t7_seq_err_end", seqerr_end, exp_seqerr);
        check("t7_n_valid", n_valid, 6);
        run_frame(1'b0, 16'd1, 32'hFFFF_FFFF, -1, 1'b0, 800);
        check("t7_seq_err_cleared", seqerr_c0, 1'b0);
        check("t7_seq_err_after", seqerr_end, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/supersample_sched.md
# supersample_sched

Sequencer in front of `supersample_top`. Accepts 8×8 9-bit pixel blocks from the IDCT stage over a valid/ready handshake and forwards them one per cycle as `valid_in`/`ch_in`/`block_in`. Channels follow MCU order: Y×4, Cb, Cr for 4:2:0, or Y, Cb, Cr for 4:4:4. After each MCU it holds off input for a programmable drain gap and counts MCUs to signal end of frame.

## Interface
- `DRAIN_CYCLES`, default 2: idle cycles inserted after each MCU's Cr block. Range 0..15.
- `MCU_W`, default 16: width of the MCU counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle frame start. Ignored unless the FSM is in IDLE.
- `mode_420`  in  1  subsampling mode: 1 = 4:2:0, 0 = 4:4:4. Sampled on an accepted `start`.
- `frame_mcus`  in  MCU_W  MCUs in the frame. Sampled on an accepted `start`.
- `in_valid`  in  1  upstream block valid.
- `in_ch`  in  2  upstream channel tag: 0 = Y, 1 = Cb, 2 = Cr.
- `in_block`  in  9×8×8  upstream block.
- `in_ready`  out  1  block accepted when `in_valid && in_ready`.
- `ss_valid`  out  1  to `supersample_top.valid_in`.
- `ss_ch`  out  2  to `supersample_top.ch_in`.
- `ss_block`  out  9×8×8  to `supersample_top.block_in`.
- `busy`  out  1  FSM not in IDLE.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `seq_err`  out  1  sticky channel-order error (see Configuration).

## Operation
- States: IDLE, Y, CB, CR, DRAIN.
- IDLE:
  - On `start`, latch `mode_420` and `frame_mcus`, clear the MCU count and Y count, clear `seq_err`, go to Y.
  - If `frame_mcus` == 0, stay in IDLE and pulse `frame_done` on the next cycle.
- `in_ready` = 1 only in Y, CB and CR. It is combinational from state, with no dependence on `in_valid`.
- Y:
  - Each accept increments the Y count.
  - Go to CB after 4 accepts (4:2:0) or 1 accept (4:4:4).
- CB: one accept, then go to CR.
- CR: one accept, then increment the MCU count, then:
  - `DRAIN_CYCLES` > 0: go to DRAIN and load the drain counter.
  - `DRAIN_CYCLES` == 0: take the end-of-MCU decision below directly.
- DRAIN: count down. At zero, take the end-of-MCU decision.
- End-of-MCU decision:
  - MCU count == latched `frame_mcus`: go to IDLE and pulse `frame_done`.
  - Otherwise: go to Y and clear the Y count.
- Output channel:
  - `ss_ch` is the channel implied by the FSM state (Y = 0, CB = 1, CR = 2), never `in_ch`.
  - `ss_block` is `in_block` registered on accept.
- `start` is ignored while `busy`.
- Arithmetic: the MCU count is MCU_W bits. Compare for equality only; no wrap is possible because the count is bounded by `frame_mcus`.

## Timing
- Latency from accept to output: 1 cycle. An accept at edge N gives `ss_valid` = 1 for the cycle after edge N.
- `ss_valid` is 0 in every cycle without a preceding accept.
- Back-to-back accepts are allowed, giving one output block per cycle. The datapath has no backpressure and no stall.
- `busy` rises the cycle after an accepted `start`.
- `frame_done` is registered. It asserts in the cycle `busy` falls.
- 4:2:0 MCU with `in_valid` held high and DRAIN_CYCLES = 2: 6 accept cycles plus 2 drain cycles, so the MCU period is 8 cycles.
- Reset values: `in_ready` = 0, `ss_valid` = 0, `ss_ch` = 0, `ss_block` = 0, `busy` = 0, `frame_done` = 0, `seq_err` = 0. State = IDLE, all counters = 0.
- Reset mid-frame: everything returns to the reset values immediately. A pending `ss_valid` is dropped, and the remainder of the frame is lost.

## Configuration
- Macro: `SUPERSAMPLE_SCHED_CHK_EN`.
- Defined:
  - On each accept, compare `in_ch` against the state's expected channel.
  - On mismatch, set `seq_err` on the next cycle. It stays set until the next accepted `start` or reset.
  - The block is still forwarded, tagged with the expected channel.
- Undefined: `in_ch` is unused and `seq_err` is tied to 0.

## Test plan
- 4:2:0 single MCU, `frame_mcus` = 1, `in_valid` held high, DRAIN_CYCLES = 2:
  - `ss_ch` = 0,0,0,0,1,2 on 6 consecutive cycles.
  - `in_ready` is low for 2 cycles after the Cr accept.
  - `frame_done` pulses once, with `busy` falling that cycle.
- 4:4:4 with `frame_mcus` = 2: `ss_ch` sequence is 0,1,2, then a 2-cycle gap, then 0,1,2. One `frame_done`.
- Upstream bubbles: drop `in_valid` randomly for a 4:2:0 frame with `frame_mcus` = 3.
  - `ss_valid` count = 18.
  - Channel order preserved.
  - `ss_block` equals the accepted `in_block` one cycle later.
- With `SUPERSAMPLE_SCHED_CHK_EN`, feed `in_ch` = 2 on the first Y accept:
  - `ss_ch` = 0 on the output.
  - `seq_err` = 1 from the next cycle, held until the next `start`.
- `frame_mcus` = 0: `frame_done` pulses the cycle after `start`. `busy` stays 0 and `ss_valid` stays 0.
- Reset and re-start:
  - Assert `rst` after the 2nd Y accept: all outputs 0 immediately.
  - A new `start` then gives a clean 0,0,0,0,1,2 sequence.
  - A `start` pulsed while `busy` is ignored and the MCU count is unchanged.
